// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter/interconnect for the serial system bus: grants one master,
// decodes the slave from leading address bits, then steers handshake and bit lines.
// Optional idle-tenure watchdog: define ARB_TIMEOUT_EN.
module serial_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_BITS    = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_breq,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_err,
  output logic [NUM_SLAVES-1:0]  s_mode,
  output logic [NUM_SLAVES-1:0]  s_wr_bus,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  input  logic [NUM_SLAVES-1:0]  s_rd_bus,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(SEL_BITS + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEL     = 3'd1;
  localparam logic [2:0] ST_CONNECT = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  if (NUM_MASTERS < 1 || SEL_BITS < 1 || NUM_SLAVES > (2 ** SEL_BITS) || TIMEOUT < 1) begin : g_param_check
    $error("serial_bus_arbiter: illegal parameter combination");
  end

  logic [2:0]             r_state;
  logic [IW-1:0]          r_rr;
  logic [IW-1:0]          r_owner;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_err;
  logic [SEL_BITS-1:0]    r_sel;
  logic [CW-1:0]          r_bitcnt;

  logic                   w_found;
  logic [IW-1:0]          w_pick;
  logic [IW-1:0]          w_rr_next;
  logic                   w_own_breq;
  logic                   w_own_valid;
  logic                   w_own_bit;
  logic [SEL_BITS-1:0]    w_sel_new;
  logic                   w_sel_ok;
  logic                   w_in_sel;
  logic                   w_connect;
  logic                   w_tmo_hit;

  // Scan downwards so the requester closest to the rr pointer wins last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int n = NUM_MASTERS - 1; n >= 0; n--) begin
      if (m_breq[(int'(r_rr) + n) % NUM_MASTERS]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_rr) + n) % NUM_MASTERS);
      end
    end
  end

  assign w_rr_next   = (r_owner == IW'(NUM_MASTERS - 1)) ? '0 : IW'(r_owner + 1'b1);
  assign w_own_breq  = m_breq[r_owner];
  assign w_own_valid = m_master_valid[r_owner];
  assign w_own_bit   = m_wr_bus[r_owner];
  assign w_sel_new   = SEL_BITS'({r_sel, w_own_bit});
  assign w_sel_ok    = ({1'b0, w_sel_new} < (SEL_BITS + 1)'(NUM_SLAVES));
  assign w_in_sel    = (r_state == ST_SEL);
  assign w_connect   = (r_state == ST_CONNECT);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo;
  logic          w_beat;

  assign w_beat    = (w_own_valid & s_slave_ready[r_sel]) |
                     (s_slave_valid[r_sel] & m_master_ready[r_owner]);
  assign w_tmo_hit = w_connect && (r_tmo == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || !w_connect || w_beat) begin
      r_tmo <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr     <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_err    <= '0;
      r_sel    <= '0;
      r_bitcnt <= '0;
    end else begin
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner  <= w_pick;
            r_grant  <= NUM_MASTERS'(1) << w_pick;
            r_sel    <= '0;
            r_bitcnt <= '0;
            r_state  <= ST_SEL;
          end
        end
        ST_SEL: begin
          // A master withdrawing mid-decode never reaches any slave.
          if (!w_own_breq) begin
            r_grant <= '0;
            r_state <= ST_RELEASE;
          end else if (w_own_valid) begin
            r_sel <= w_sel_new;
            if (r_bitcnt == CW'(SEL_BITS - 1)) begin
              if (w_sel_ok) begin
                r_state <= ST_CONNECT;
              end else begin
                r_err   <= r_grant;
                r_state <= ST_ERR;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_CONNECT: begin
          if (!w_own_breq || w_tmo_hit) begin
            r_grant <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_rr    <= w_rr_next;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          if (!w_own_breq) begin
            r_grant <= '0;
            r_rr    <= w_rr_next;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_grant = r_grant;

  genvar gi;
  for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    logic w_hit;
    assign w_hit              = w_connect && (r_sel == SEL_BITS'(gi));
    assign s_mode[gi]         = w_hit & m_mode[r_owner];
    assign s_wr_bus[gi]       = w_hit & w_own_bit;
    assign s_master_valid[gi] = w_hit & w_own_valid & ~w_tmo_hit;
    assign s_master_ready[gi] = w_hit & m_master_ready[r_owner];
  end

  for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    logic w_own;
    assign w_own             = (r_owner == IW'(gi));
    assign m_slave_ready[gi] = w_own & (w_in_sel | (w_connect & s_slave_ready[r_sel]));
    assign m_slave_valid[gi] = w_own & w_connect & s_slave_valid[r_sel];
    assign m_rd_bus[gi]      = w_own & w_connect & s_rd_bus[r_sel];
    assign m_err[gi]         = r_err[gi] | (w_own & w_tmo_hit);
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: a 2-master/4-slave instance plus a
// 3-slave instance sharing the same stimulus for the bad-decode path.
module tb_serial_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] m_breq, m_mode, m_wr_bus, m_master_valid, m_master_ready;
  logic [1:0] m_grant, m_slave_ready, m_slave_valid, m_rd_bus, m_err;
  logic [3:0] s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic [3:0] s_rd_bus, s_slave_ready, s_slave_valid;

  logic [1:0] e_grant, e_slave_ready, e_slave_valid, e_rd_bus, e_err;
  logic [2:0] e_mode, e_wr_bus, e_smv, e_smr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter #(.NUM_MASTERS(2), .NUM_SLAVES(4), .SEL_BITS(2), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst),
    .m_breq(m_breq), .m_grant(m_grant), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
    .m_master_valid(m_master_valid), .m_slave_ready(m_slave_ready),
    .m_master_ready(m_master_ready), .m_slave_valid(m_slave_valid),
    .m_rd_bus(m_rd_bus), .m_err(m_err),
    .s_mode(s_mode), .s_wr_bus(s_wr_bus), .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready), .s_rd_bus(s_rd_bus),
    .s_slave_ready(s_slave_ready), .s_slave_valid(s_slave_valid)
  );

  serial_bus_arbiter #(.NUM_MASTERS(2), .NUM_SLAVES(3), .SEL_BITS(2), .TIMEOUT(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .m_breq(m_breq), .m_grant(e_grant), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
    .m_master_valid(m_master_valid), .m_slave_ready(e_slave_ready),
    .m_master_ready(m_master_ready), .m_slave_valid(e_slave_valid),
    .m_rd_bus(e_rd_bus), .m_err(e_err),
    .s_mode(e_mode), .s_wr_bus(e_wr_bus), .s_master_valid(e_smv),
    .s_master_ready(e_smr), .s_rd_bus(s_rd_bus[2:0]),
    .s_slave_ready(s_slave_ready[2:0]), .s_slave_valid(s_slave_valid[2:0])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[%0t] FAIL %s got=%h exp=%h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s got=%h", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] data;
  logic [7:0] rx;
  logic [3:0] rpat;
  int         n;

  initial begin
    rst = 1'b1;
    m_breq = '0; m_mode = '0; m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0;
    s_rd_bus = '0; s_slave_ready = 4'b1111; s_slave_valid = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_grant", m_grant, 0);
    check("rst_s_valid", s_master_valid, 0);
    check("rst_m_ready", m_slave_ready, 0);
    check("rst_m_valid", m_slave_valid, 0);
    check("rst_err", m_err, 0);
    check("rst_s_mode", s_mode, 0);

    // M0 write 0xd3 to the bridge (sel 2'b11)
    m_breq = 2'b01;
    #1 check("wr_grant_lat0", m_grant, 0);
    tick();
    check("wr_grant", m_grant, 2'b01);
    check("wr_sel_ready", m_slave_ready, 2'b01);
    m_master_valid = 2'b01; m_wr_bus = 2'b01; m_mode = 2'b01;
    #1 check("wr_sel_not_fwd", s_master_valid, 0);
    tick(); tick();
    data = 8'hd3;
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      m_wr_bus = {1'b0, data[i]};
      #1;
      check("wr_s_valid", s_master_valid, 4'b1000);
      check("wr_s_bit", s_wr_bus, {data[i], 3'b000});
      if (s_master_valid[3]) rx = {rx[6:0], s_wr_bus[3]};
      tick();
    end
    check("wr_s_mode", s_mode, 4'b1000);
    check("wr_bridge_byte", rx, 8'hd3);
    m_master_valid = '0; m_breq = '0; m_mode = '0;
    tick();
    check("wr_release_grant", m_grant, 0);
    tick();

    // Reset mid-CONNECT (rr pointer is 1 here, so M1 wins first)
    m_breq = 2'b11;
    tick();
    check("rc_grant_m1", m_grant, 2'b10);
    m_master_valid = 2'b11; m_wr_bus = 2'b00;
    tick(); tick();
    check("rc_connect_s0", s_master_valid, 4'b0001);
    rst = 1'b1;
    tick();
    check("rc_grant_zero", m_grant, 0);
    check("rc_s_valid_zero", s_master_valid, 0);
    check("rc_m_ready_zero", m_slave_ready, 0);
    rst = 1'b0;
    tick();
    check("rc_rr_zero", m_grant, 2'b01);
    m_master_valid = '0; m_breq = '0;
    tick(); tick();

    // Round-robin rotation with simultaneous requests
    pulse_reset();
    m_breq = 2'b11;
    tick();
    check("rr_first_m0", m_grant, 2'b01);
    m_breq = 2'b10;
    tick();
    check("rr_abort_release", m_grant, 0);
    m_breq = 2'b11;
    tick(); tick();
    check("rr_second_m1", m_grant, 2'b10);
    m_breq = 2'b01;
    tick();
    m_breq = 2'b11;
    tick(); tick();
    check("rr_third_m0", m_grant, 2'b01);
    m_breq = '0;
    tick(); tick();

    // M1 read from slave 1 (sel 2'b01)
    m_breq = 2'b10;
    tick();
    check("rd_grant", m_grant, 2'b10);
    m_master_valid = 2'b10; m_wr_bus = 2'b00;
    tick();
    m_wr_bus = 2'b10;
    tick();
    m_master_valid = '0; m_wr_bus = '0; m_master_ready = 2'b10; s_slave_valid = 4'b0010;
    rpat = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      s_rd_bus = rpat[i] ? 4'b0010 : 4'b1101;
      #1;
      check("rd_bit", m_rd_bus, {rpat[i], 1'b0});
      check("rd_m_valid", m_slave_valid, 2'b10);
      check("rd_s_ready", s_master_ready, 4'b0010);
      tick();
    end
    check("rd_s_mode", s_mode, 0);
    m_breq = '0; m_master_ready = '0; s_slave_valid = '0; s_rd_bus = '0;
    tick(); tick();

    // Bad decode on the 3-slave instance (sel 2'b11)
    pulse_reset();
    m_breq = 2'b01;
    tick();
    m_master_valid = 2'b01; m_wr_bus = 2'b01;
    #1 check("err_none_in_sel", e_err, 0);
    tick(); tick();
    check("err_pulse", e_err, 2'b01);
    check("err_no_s_valid", e_smv, 0);
    check("err_grant_held", e_grant, 2'b01);
    tick();
    check("err_pulse_end", e_err, 0);
    check("err_grant_still", e_grant, 2'b01);
    check("err_no_s_valid2", e_smv, 0);
    m_breq = '0; m_master_valid = '0;
    tick();
    check("err_grant_drop", e_grant, 0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Stalled tenure is cut off after TIMEOUT idle cycles
    pulse_reset();
    m_breq = 2'b01;
    tick();
    m_master_valid = 2'b01; m_wr_bus = 2'b01;
    tick();
    m_wr_bus = 2'b00;
    tick();
    m_master_valid = '0; m_breq = 2'b11;
    n = 0;
    while (n < 20 && !m_err[0]) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 8);
    check("tmo_err", m_err, 2'b01);
    tick();
    check("tmo_grant_drop", m_grant, 0);
    tick(); tick();
    check("tmo_next_m1", m_grant, 2'b10);
    m_breq = '0;
    tick(); tick();
`else
    n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
